// File: rtl/word_serializer.sv
// -----------------------------------------------------------------------------
// word_serializer
//   Parallel-to-serial transmit stage. Accepts WORD_W-bit words over a
//   valid/ready handshake and shifts them out MSB first, one bit per t_clk.
//   Consecutive words follow each other with no gap bits. A one-entry holding
//   register lets the producer hand over the next word while the current one
//   is still shifting.
//
// Optional feature (macro SER_PATTERN_EN):
//   Once the first real word has gone out, the line never idles. When a word
//   ends and nothing is waiting, the PATTERN fill word is shifted instead and
//   fill_word is raised for its duration. A real word that arrives during a
//   fill word waits in the holding register until the fill word has ended.
//   With the macro undefined there is no fill logic and fill_word is tied low.
//
// Ports
//   t_clk        in   bit clock, all logic on posedge
//   rst_n        in   synchronous active-low reset
//   word_in      in   parallel word to send
//   word_valid   in   word_in valid
//   word_ready   out  block can accept word_in this cycle (flop-only path)
//   data_out     out  serial output, MSB first
//   frame_start  out  high while bit WORD_W-1 of a word is on data_out
//   busy         out  shifter active or holding register full
//   fill_word    out  high while a PATTERN fill word is shifting
// -----------------------------------------------------------------------------
module word_serializer #(
  parameter int                WORD_W     = 32,
  parameter logic              IDLE_LEVEL = 1'b0
`ifdef SER_PATTERN_EN
  ,
  parameter logic [WORD_W-1:0] PATTERN    = 32'h5A5A_C33C
`endif
) (
  input  logic              t_clk,
  input  logic              rst_n,
  input  logic [WORD_W-1:0] word_in,
  input  logic              word_valid,
  output logic              word_ready,
  output logic              data_out,
  output logic              frame_start,
  output logic              busy,
  output logic              fill_word
);

  localparam int                CNT_W    = $clog2(WORD_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_W - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [WORD_W-1:0]   shreg_q, shreg_d;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [WORD_W-1:0]   hold_q, hold_d;
  logic                hold_full_q, hold_full_d;
  logic                ready_q;
`ifdef SER_PATTERN_EN
  logic                fill_q, fill_d;
`endif

  logic active;
  logic accept;
  logic at_last;
  logic can_load;
  logic word_avail;

  assign active     = (state_q == SHIFT);
  assign word_ready = ready_q & ~hold_full_q;
  assign accept     = word_valid & word_ready;
  assign at_last    = active & (bit_cnt_q == LAST_BIT);
  // The shifter can take a new word when idle or on the final bit of a word,
  // which is what makes consecutive words abut with no gap.
  assign can_load   = ~active | at_last;
  assign word_avail = hold_full_q | accept;

  // NOTE: every next-state variable gets its default (hold value) first, so
  // no path through this block leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    bit_cnt_d   = bit_cnt_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
`ifdef SER_PATTERN_EN
    fill_d      = fill_q;
`endif

    if (active) begin
      shreg_d   = shreg_q << 1;
      bit_cnt_d = bit_cnt_q + CNT_W'(1);
    end

    if (can_load && word_avail) begin
      // A held word is older than one offered this cycle, so it goes first.
      shreg_d   = hold_full_q ? hold_q : word_in;
      bit_cnt_d = '0;
      state_d   = SHIFT;
`ifdef SER_PATTERN_EN
      fill_d    = 1'b0;
`endif
    end else if (at_last) begin
`ifdef SER_PATTERN_EN
      shreg_d   = PATTERN;
      bit_cnt_d = '0;
      fill_d    = 1'b1;
`else
      state_d   = IDLE;
`endif
    end

    // word_ready is low while the hold register is full, so a refill and a
    // drain never coincide.
    if (accept && !can_load) begin
      hold_d      = word_in;
      hold_full_d = 1'b1;
    end else if (can_load && hold_full_q) begin
      hold_full_d = 1'b0;
    end
  end

  always_ff @(posedge t_clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      bit_cnt_q   <= '0;
      hold_full_q <= 1'b0;
      ready_q     <= 1'b0;
`ifdef SER_PATTERN_EN
      fill_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      bit_cnt_q   <= bit_cnt_d;
      hold_full_q <= hold_full_d;
      ready_q     <= 1'b1;
`ifdef SER_PATTERN_EN
      fill_q      <= fill_d;
`endif
    end
  end

  // NOTE: the hold data register has no reset; its contents are only ever
  // read when hold_full_q is set, and that flag is reset.
  always_ff @(posedge t_clk) begin
    hold_q <= hold_d;
  end

  assign data_out    = active ? shreg_q[WORD_W-1] : IDLE_LEVEL;
  assign frame_start = active & (bit_cnt_q == '0);
  assign busy        = active | hold_full_q;
`ifdef SER_PATTERN_EN
  assign fill_word   = active & fill_q;
`else
  assign fill_word   = 1'b0;
`endif

endmodule

// File: tb/tb_word_serializer.sv
// -----------------------------------------------------------------------------
// tb_word_serializer
//   Scoreboard bench. The reference model is the serial line itself: every
//   accepted word is appended to an expected bit queue, and the line must play
//   that queue back one bit per cycle with no gaps, idling at IDLE_LEVEL when
//   the queue is empty. Hold-register occupancy follows from the queue depth:
//   more than one word's worth of pending bits means a word is waiting.
// -----------------------------------------------------------------------------
module tb_word_serializer;

  localparam int          W        = 32;
  localparam logic        IDLE_LVL = 1'b0;
  localparam logic [31:0] PAT      = 32'h5A5A_C33C;

  logic         t_clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] word_in = '0;
  logic         word_valid = 1'b0;
  logic         word_ready;
  logic         data_out;
  logic         frame_start;
  logic         busy;
  logic         fill_word;

  word_serializer dut (
    .t_clk       (t_clk),
    .rst_n       (rst_n),
    .word_in     (word_in),
    .word_valid  (word_valid),
    .word_ready  (word_ready),
    .data_out    (data_out),
    .frame_start (frame_start),
    .busy        (busy),
    .fill_word   (fill_word)
  );

  always #5 t_clk = ~t_clk;

  typedef struct {
    logic b;
    logic first;
    logic fill;
  } exp_bit_t;

  exp_bit_t exp_q[$];
  int       checks       = 0;
  int       errors       = 0;
  int       real_pending = 0;
  bit       started      = 1'b0;
  bit       rst_at_edge  = 1'b1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%h expected=%h", name, $time, got, exp);
    end
  endtask

  // Remember whether the most recent edge was a reset edge.
  always @(posedge t_clk) rst_at_edge <= !rst_n;

  // Monitor: compares the line against the expected bit stream every cycle.
  always @(negedge t_clk) begin
    exp_bit_t e;
    if (rst_at_edge) begin
      exp_q.delete();
      real_pending = 0;
      started      = 1'b0;
      check("rst_data_out",    data_out,    IDLE_LVL);
      check("rst_word_ready",  word_ready,  0);
      check("rst_busy",        busy,        0);
      check("rst_frame_start", frame_start, 0);
      check("rst_fill_word",   fill_word,   0);
    end else begin
`ifdef SER_PATTERN_EN
      if (exp_q.size() == 0 && started) begin
        for (int i = W - 1; i >= 0; i--) exp_q.push_back('{PAT[i], (i == W - 1), 1'b1});
      end
`endif
      check("word_ready", word_ready, (exp_q.size() <= W) ? 1 : 0);
      check("busy",       busy,       (exp_q.size() > 0) ? 1 : 0);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (!e.fill) real_pending--;
        check("data_out",    data_out,    e.b);
        check("frame_start", frame_start, e.first);
        check("fill_word",   fill_word,   e.fill);
      end else begin
        check("idle_data_out",    data_out,    IDLE_LVL);
        check("idle_frame_start", frame_start, 0);
        check("idle_fill_word",   fill_word,   0);
      end
    end
  end

  task automatic push_word(input logic [W-1:0] w);
    for (int i = W - 1; i >= 0; i--) exp_q.push_back('{w[i], (i == W - 1), 1'b0});
    real_pending += W;
    started = 1'b1;
  endtask

  // One bus cycle: drive after the falling edge, record the accept at the
  // following rising edge.
  task automatic step(input logic v, input logic [W-1:0] w, output bit acc);
    @(negedge t_clk);
    word_valid = v;
    word_in    = w;
    acc        = v && word_ready && rst_n;
    @(posedge t_clk);
    if (acc) push_word(w);
  endtask

  task automatic send(input logic [W-1:0] w);
    bit acc = 1'b0;
    int n   = 0;
    while (!acc && n < 200) begin
      step(1'b1, w, acc);
      n++;
    end
    check("send_accepted", acc, 1);
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) step(1'b0, $urandom, acc);
  endtask

  task automatic drain();
    int n = 0;
    while (real_pending > 0 && n < 2000) begin
      idle(1);
      n++;
    end
    check("drain_done", (real_pending == 0) ? 1 : 0, 1);
  endtask

  task automatic do_reset(input int n);
    @(negedge t_clk);
    rst_n      = 1'b0;
    word_valid = 1'b0;
    repeat (n) @(posedge t_clk);
    @(negedge t_clk);
    rst_n = 1'b1;
    @(posedge t_clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog t=%0t got=running expected=finished", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset held for three cycles from time zero.
    repeat (3) @(posedge t_clk);
    @(negedge t_clk);
    rst_n = 1'b1;
    @(posedge t_clk);

    // Single word, then idle line.
    send(32'hA500_0001);
    idle(40);

    // Three words with valid held high: back-to-back, hold register in use.
    send(32'hFFFF_0000);
    send(32'h0000_FFFF);
    send(32'h1234_5678);
    drain();
    idle(3);

    // Reset in the middle of a word with a second word in the hold register.
    send(32'hDEAD_BEEF);
    send(32'hCAFE_F00D);
    idle(8);
    do_reset(2);
    send(32'h8000_0001);
    drain();
    idle(3);

    // Randomised traffic with random gaps between offers.
    for (int i = 0; i < 64; i++) begin
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 40));
      send($urandom);
    end
    drain();
    idle(5);

`ifdef SER_PATTERN_EN
    // Fill words after the first real word; a new word inserted mid-fill.
    send(32'h0F0F_1234);
    idle(80);
    send(32'hB00B_1E5F);
    idle(70);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
